mem_stage: RTL and testbench

- Memory-access stage; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Holds the data memory and performs word, halfword and byte loads and stores.
- Latches the syscall halt state and keeps retired-instruction and memory-op counters for the board display.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Holds the word-organised data memory, performs word/half/byte loads
// (combinational) and stores (rising edge), latches the syscall halt state
// and keeps retired-instruction / memory-op counters for the board display.
module mem_stage #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              Enable_in,
   input  logic [31:0]       Order_in,
   input  logic              Memwrite_in,
   input  logic              Memtoreg_in,
   input  logic              Signedext_in,
   input  logic [1:0]        Mode_in,
   input  logic              Syscall_in,
   input  logic [31:0]       ALU_Result1_in,
   input  logic [31:0]       RD2_in,
   output logic [31:0]       Mem_Data_out,
   output logic              Enable_out,
   output logic              Halt_out,
   output logic [31:0]       Display_out,
   output logic [CNT_W-1:0]  Retired_cnt_out,
   output logic [CNT_W-1:0]  Memop_cnt_out,
   input  logic [ADDR_W-1:0] Dbg_addr_in,
   output logic [31:0]       Dbg_data_out
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               halt_q, halt_d;
   logic [31:0]        display_q, display_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [CNT_W-1:0]   memop_q, memop_d;

   // Memory contents are deliberately never reset.
   logic [31:0]        mem_q [0:DEPTH-1];

   logic [ADDR_W-1:0]  word_idx_s;
   logic [1:0]         lane_s;
   logic [31:0]        rd_word_s;
   logic               active_s;
   logic               we_s;
   logic [3:0]         be_s;
   logic [31:0]        wdata_s;
   logic [15:0]        half_s;
   logic [7:0]         byte_s;

   // Upper address bits are dropped so out-of-range addresses wrap.
   assign word_idx_s = ALU_Result1_in[ADDR_W+1:2];
   assign lane_s     = ALU_Result1_in[1:0];
   assign rd_word_s  = mem_q[word_idx_s];
   assign active_s   = Enable_in & (state_q == ST_RUN);
   assign we_s       = Memwrite_in & active_s & ~clr;

   assign Enable_out      = Enable_in & ~halt_q;
   assign Halt_out        = halt_q;
   assign Display_out     = display_q;
   assign Retired_cnt_out = retired_q;
   assign Memop_cnt_out   = memop_q;
   assign Dbg_data_out    = mem_q[Dbg_addr_in];

   // Byte enables and lane-replicated store data for the selected access size.
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = RD2_in;
      case (Mode_in)
         2'b01: begin
            be_s    = ALU_Result1_in[1] ? 4'b1100 : 4'b0011;
            wdata_s = {RD2_in[15:0], RD2_in[15:0]};
         end
         2'b10: begin
            be_s    = 4'b0001 << lane_s;
            wdata_s = {4{RD2_in[7:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = RD2_in;
         end
      endcase
   end

   // Load path: select half/byte from the addressed word and extend it.
   always_comb begin
      half_s       = ALU_Result1_in[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      byte_s       = rd_word_s[{lane_s, 3'b000} +: 8];
      Mem_Data_out = rd_word_s;
      case (Mode_in)
         2'b01: begin
            if (Signedext_in) begin
               Mem_Data_out = {{16{half_s[15]}}, half_s};
            end else begin
               Mem_Data_out = {16'h0000, half_s};
            end
         end
         2'b10: begin
            if (Signedext_in) begin
               Mem_Data_out = {{24{byte_s[7]}}, byte_s};
            end else begin
               Mem_Data_out = {24'h000000, byte_s};
            end
         end
         default: begin
            Mem_Data_out = rd_word_s;
         end
      endcase
   end

   // Byte-masked synchronous memory write; old data stays visible this cycle.
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_q[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
            end
         end
      end
   end

   // Next-state logic: halt FSM, display latch and statistic counters.
   always_comb begin
      state_d   = state_q;
      halt_d    = halt_q;
      display_d = display_q;
      retired_d = retired_q;
      memop_d   = memop_q;
      case (state_q)
         ST_RUN: begin
            if (Enable_in) begin
               if (Order_in != 32'h0000_0000) begin
                  retired_d = retired_q + CNT_ONE;
               end else begin
                  retired_d = retired_q;
               end
               if (Memwrite_in | Memtoreg_in) begin
                  memop_d = memop_q + CNT_ONE;
               end else begin
                  memop_d = memop_q;
               end
               if (Syscall_in) begin
                  state_d   = ST_HALT;
                  halt_d    = 1'b1;
                  display_d = RD2_in;
               end else begin
                  state_d   = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State register with asynchronous active-high clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= ST_RUN;
         halt_q    <= 1'b0;
         display_q <= 32'h0000_0000;
         retired_q <= {CNT_W{1'b0}};
         memop_q   <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         halt_q    <= halt_d;
         display_q <= display_d;
         retired_q <= retired_d;
         memop_q   <= memop_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Counters are built 4 bits wide so wrap-around is reachable by stimulus.
module tb_mem_stage;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              clr;
   logic              Enable_in;
   logic [31:0]       Order_in;
   logic              Memwrite_in;
   logic              Memtoreg_in;
   logic              Signedext_in;
   logic [1:0]        Mode_in;
   logic              Syscall_in;
   logic [31:0]       ALU_Result1_in;
   logic [31:0]       RD2_in;
   logic [31:0]       Mem_Data_out;
   logic              Enable_out;
   logic              Halt_out;
   logic [31:0]       Display_out;
   logic [CNT_W-1:0]  Retired_cnt_out;
   logic [CNT_W-1:0]  Memop_cnt_out;
   logic [ADDR_W-1:0] Dbg_addr_in;
   logic [31:0]       Dbg_data_out;

   int errors = 0;
   int checks = 0;

   mem_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .clr             (clr),
      .Enable_in       (Enable_in),
      .Order_in        (Order_in),
      .Memwrite_in     (Memwrite_in),
      .Memtoreg_in     (Memtoreg_in),
      .Signedext_in    (Signedext_in),
      .Mode_in         (Mode_in),
      .Syscall_in      (Syscall_in),
      .ALU_Result1_in  (ALU_Result1_in),
      .RD2_in          (RD2_in),
      .Mem_Data_out    (Mem_Data_out),
      .Enable_out      (Enable_out),
      .Halt_out        (Halt_out),
      .Display_out     (Display_out),
      .Retired_cnt_out (Retired_cnt_out),
      .Memop_cnt_out   (Memop_cnt_out),
      .Dbg_addr_in     (Dbg_addr_in),
      .Dbg_data_out    (Dbg_data_out)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [31:0] order, input logic mw,
                        input logic mr, input logic sx, input logic [1:0] mode,
                        input logic sys, input logic [31:0] addr, input logic [31:0] data);
      Enable_in      = en;
      Order_in       = order;
      Memwrite_in    = mw;
      Memtoreg_in    = mr;
      Signedext_in   = sx;
      Mode_in        = mode;
      Syscall_in     = sys;
      ALU_Result1_in = addr;
      RD2_in         = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] OP = 32'h0000_0123;

   initial begin
      clr = 1'b1;
      Dbg_addr_in = 10'd0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #3;
      chk("rst_halt", {31'h0, Halt_out}, 32'h0);
      chk("rst_disp", Display_out, 32'h0);
      chk("rst_ret", {28'h0, Retired_cnt_out}, 32'h0);
      chk("rst_memop", {28'h0, Memop_cnt_out}, 32'h0);
      chk("rst_enout", {31'h0, Enable_out}, 32'h0);
      step();
      #2 clr = 1'b0;

      // sw 0xDEADBEEF @0x10, then lw
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
      step();
      drive(1'b1, OP, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      #1;
      chk("lw_data", Mem_Data_out, 32'hDEADBEEF);
      Mode_in = 2'b11;
      #1;
      chk("mode11_word", Mem_Data_out, 32'hDEADBEEF);
      Mode_in = 2'b00;
      step();
      chk("lw_memop", {28'h0, Memop_cnt_out}, 32'd2);
      chk("lw_ret", {28'h0, Retired_cnt_out}, 32'd2);

      // Sub-word stores onto a zeroed word at 0x20
      Dbg_addr_in = 10'd8;
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      step();
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0000_007F);
      #1;
      chk("rdw_old", Dbg_data_out, 32'h0);
      step();
      chk("sb_word", Dbg_data_out, 32'h0000_7F00);
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_8001);
      step();
      chk("sh_word", Dbg_data_out, 32'h8001_7F00);
      drive(1'b1, OP, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
      #1;
      chk("lb_21", Mem_Data_out, 32'h0000_007F);
      drive(1'b1, OP, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h23, 32'h0);
      #1;
      chk("lb_signed_23", Mem_Data_out, 32'hFFFF_FF80);
      drive(1'b1, OP, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0);
      #1;
      chk("lh_signed_22", Mem_Data_out, 32'hFFFF_8001);
      drive(1'b1, OP, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0);
      #1;
      chk("lh_a0_ignored", Mem_Data_out, 32'hFFFF_8001);
      drive(1'b1, OP, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
      #1;
      chk("lhu_22", Mem_Data_out, 32'h0000_8001);
      step();
      chk("sub_ret", {28'h0, Retired_cnt_out}, 32'd6);
      chk("sub_memop", {28'h0, Memop_cnt_out}, 32'd6);

      // Disabled store and bubble
      drive(1'b0, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'hFFFF_FFFF);
      #1;
      chk("dis_enout", {31'h0, Enable_out}, 32'h0);
      step();
      chk("dis_mem", Dbg_data_out, 32'h8001_7F00);
      chk("dis_ret", {28'h0, Retired_cnt_out}, 32'd6);
      chk("dis_memop", {28'h0, Memop_cnt_out}, 32'd6);
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #1;
      chk("run_enout", {31'h0, Enable_out}, 32'h1);
      step();
      chk("bubble_ret", {28'h0, Retired_cnt_out}, 32'd6);

      // Syscall halts; later store ignored
      drive(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0022);
      step();
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h1111_1111);
      #1;
      chk("sys_halt", {31'h0, Halt_out}, 32'h1);
      chk("sys_disp", Display_out, 32'h0000_0022);
      chk("sys_enout", {31'h0, Enable_out}, 32'h0);
      chk("sys_ret", {28'h0, Retired_cnt_out}, 32'd7);
      step();
      chk("halt_mem", Dbg_data_out, 32'h8001_7F00);
      chk("halt_ret", {28'h0, Retired_cnt_out}, 32'd7);
      chk("halt_memop", {28'h0, Memop_cnt_out}, 32'd6);
      chk("halt_disp", Display_out, 32'h0000_0022);

      // Asynchronous clear between edges
      #1 clr = 1'b1;
      #1;
      chk("clr_halt", {31'h0, Halt_out}, 32'h0);
      chk("clr_ret", {28'h0, Retired_cnt_out}, 32'd0);
      chk("clr_memop", {28'h0, Memop_cnt_out}, 32'd0);
      chk("clr_mem_kept", Dbg_data_out, 32'h8001_7F00);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #1 clr = 1'b0;

      // Address wrap
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, (32'd4 << ADDR_W) + 32'd8, 32'h1234_5678);
      step();
      Dbg_addr_in = 10'd2;
      #1;
      chk("wrap_data", Dbg_data_out, 32'h1234_5678);
      chk("wrap_ret", {28'h0, Retired_cnt_out}, 32'd1);

      // Store pending while clr is held across an edge
      drive(1'b1, OP, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h8, 32'hCAFE_F00D);
      clr = 1'b1;
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #1 clr = 1'b0;
      chk("clrst_mem", Dbg_data_out, 32'h1234_5678);
      chk("clrst_ret", {28'h0, Retired_cnt_out}, 32'd0);

      // Counter wrap: 15 retirements reach max, one more wraps to 0
      drive(1'b1, OP, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         step();
      end
      chk("cnt_max", {28'h0, Retired_cnt_out}, 32'd15);
      step();
      chk("cnt_wrap", {28'h0, Retired_cnt_out}, 32'd0);
      chk("cnt_memop", {28'h0, Memop_cnt_out}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
